// File: rtl/strip_frame_driver.sv
// strip_frame_driver: serialises a frame of RGB/RGBW pixels onto a single-wire LED strip.
// Each bit is a fixed TBIT-cycle period whose high time encodes the bit (T1H for 1, T0H for 0).
// After the last bit of the last LED the line is held low for TRESET cycles so the strip latches.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request one frame; honoured only when idle
//   frame      - pixel data, LED i at [i*BITS_PER_LED +: BITS_PER_LED], MSB sent first
//   brightness - global scale applied to every 8-bit colour field
//   DO         - serial data line
//   busy       - high while bits or the latch gap are in progress
//   done       - one-cycle pulse on the first idle cycle after the latch gap
//   led_index  - LED currently being sent (0 when not sending)
module strip_frame_driver #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned T0H          = 20,
  parameter int unsigned T1H          = 40,
  parameter int unsigned TBIT         = 61,
  parameter int unsigned TRESET       = 2500,
  localparam int unsigned LED_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [NUM_LEDS*BITS_PER_LED-1:0] frame,
  input  logic [7:0]                       brightness,
  output logic                             DO,
  output logic                             busy,
  output logic                             done,
  output logic [LED_W-1:0]                 led_index
);

  localparam int unsigned CNT_MAX    = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W      = $clog2(BITS_PER_LED + 1);
  localparam int unsigned BIDX_W     = $clog2(BITS_PER_LED);
  localparam int unsigned NUM_FIELDS = BITS_PER_LED / 8;
  localparam int unsigned FRAME_W    = NUM_LEDS * BITS_PER_LED;

  localparam logic [CNT_W-1:0] T0H_LAST    = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T1H_LAST    = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] TBIT_LAST   = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] TRESET_LAST = CNT_W'(TRESET - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST   = BIT_W'(BITS_PER_LED - 1);
  localparam logic [LED_W-1:0] LED_LAST    = LED_W'(NUM_LEDS - 1);

  if (NUM_LEDS < 1 || T0H == 0 || T1H <= T0H || TBIT <= T1H || TRESET < 1 ||
      (BITS_PER_LED != 24 && BITS_PER_LED != 32)) begin : gen_bad_params
    $error("strip_frame_driver: illegal NUM_LEDS, timing or BITS_PER_LED parameters");
  end

  typedef enum logic [1:0] {
    StIdle,
    StSendHigh,
    StSendLow,
    StLatch
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [7:0]           bright_q, bright_d;
  logic                 done_q, done_d;

  logic [BITS_PER_LED-1:0] led_raw;
  logic [BITS_PER_LED-1:0] led_scaled;
  logic [15:0]             prod;
  logic                    cur_bit;
  logic [CNT_W-1:0]        hi_last;

  // Select the shadowed word of the LED in flight.
  always_comb begin
    led_raw = frame_q[BITS_PER_LED-1:0];
    for (int i = 1; i < NUM_LEDS; i++) begin
      if (led_q == LED_W'(i)) begin
        led_raw = frame_q[i*BITS_PER_LED +: BITS_PER_LED];
      end
    end
  end

  // (c * (brightness + 1)) >> 8 per colour field; 255*256 still fits 16 bits.
  always_comb begin
    led_scaled = '0;
    prod       = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      prod = {8'd0, led_raw[f*8 +: 8]} * ({8'd0, bright_q} + 16'd1);
      led_scaled[f*8 +: 8] = 8'(prod >> 8);
    end
  end

  assign cur_bit = led_scaled[bit_q[BIDX_W-1:0]];
  assign hi_last = cur_bit ? T1H_LAST : T0H_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      led_q    <= '0;
      frame_q  <= '0;
      bright_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      led_q    <= led_d;
      frame_q  <= frame_d;
      bright_q <= bright_d;
      done_q   <= done_d;
    end
  end

  // cnt_q runs 0..TBIT-1 across both halves of a bit, so the low phase ends at a fixed count
  // regardless of which high time was used.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    led_d    = led_q;
    frame_d  = frame_q;
    bright_d = bright_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          frame_d  = frame;
          bright_d = brightness;
          cnt_d    = '0;
          bit_d    = BIT_FIRST;
          led_d    = '0;
          state_d  = StSendHigh;
        end
      end
      StSendHigh: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == hi_last) begin
          state_d = StSendLow;
        end
      end
      StSendLow: begin
        if (cnt_q == TBIT_LAST) begin
          cnt_d   = '0;
          state_d = StSendHigh;
          if (bit_q == '0) begin
            bit_d = BIT_FIRST;
            if (led_q == LED_LAST) begin
              led_d   = '0;
              state_d = StLatch;
            end else begin
              led_d = led_q + LED_W'(1);
            end
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLatch: begin
        if (cnt_q == TRESET_LAST) begin
          cnt_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign DO        = (state_q == StSendHigh);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign led_index = (state_q == StSendHigh || state_q == StSendLow) ? led_q : '0;

endmodule

// File: tb/tb_strip_frame_driver.sv
module tb_strip_frame_driver;
  localparam int N  = 2;
  localparam int T0 = 2;
  localparam int T1 = 4;
  localparam int TB = 6;
  localparam int TR = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [47:0] frame_a;
  logic [63:0] frame_b;
  logic [7:0]  brightness;
  logic        do_a, busy_a, done_a, do_b, busy_b, done_b;
  logic [0:0]  led_a, led_b;

  always #5 clk = ~clk;

  strip_frame_driver #(
    .NUM_LEDS(N), .BITS_PER_LED(24), .T0H(T0), .T1H(T1), .TBIT(TB), .TRESET(TR)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .frame(frame_a), .brightness(brightness),
    .DO(do_a), .busy(busy_a), .done(done_a), .led_index(led_a)
  );

  strip_frame_driver #(
    .NUM_LEDS(N), .BITS_PER_LED(32), .T0H(T0), .T1H(T1), .TBIT(TB), .TRESET(TR)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .frame(frame_b), .brightness(brightness),
    .DO(do_b), .busy(busy_b), .done(done_b), .led_index(led_b)
  );

  // The monitor watches whichever instance sel points at.
  bit   sel = 1'b0;
  logic do_m, busy_m, done_m;
  logic [0:0] led_m;
  assign do_m   = sel ? do_b : do_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign led_m  = sel ? led_b : led_a;

  typedef struct {
    bit is_frame;
    int val;
    int led;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int last_busy_len = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: expand a frame into the per-bit high times the strip should see.
  task automatic push_model(input logic [63:0] fr, input int bpl, input int br);
    exp_t e;
    int nbits;
    nbits = 0;
    for (int led = 0; led < N; led++) begin
      for (int f = bpl / 8 - 1; f >= 0; f--) begin
        int c, s;
        c = int'((fr >> (led * bpl + f * 8)) & 64'hFF);
        s = (c * (br + 1)) / 256;
        for (int b = 7; b >= 0; b--) begin
          e.is_frame = 1'b0;
          e.led      = led;
          e.val      = ((s >> b) & 1) != 0 ? T1 : T0;
          exp_q.push_back(e);
          nbits++;
        end
      end
    end
    e.is_frame = 1'b1;
    e.led      = 0;
    e.val      = nbits * TB + TR;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  bit prev_do = 0, prev_busy = 0, first_bit = 0;
  int hi_len = 0, since_rise = 0, busy_len = 0, cur_hi = 0;

  always @(negedge clk) begin
    exp_t e;
    bit ok;
    if (!rst_n) begin
      prev_do    = 0;
      prev_busy  = 0;
      first_bit  = 0;
      hi_len     = 0;
      since_rise = 0;
      busy_len   = 0;
    end else begin
      if (busy_m && !prev_busy) first_bit = 1;
      if (do_m && !prev_do) begin
        if (!first_bit) check("bit_period", since_rise, TB);
        first_bit = 0;
        ok = (exp_q.size() > 0) && !exp_q[0].is_frame;
        check("bit_expected", ok, 1);
        if (ok) begin
          e = exp_q.pop_front();
          cur_hi = e.val;
          check("led_index", int'(led_m), e.led);
        end
        hi_len     = 0;
        since_rise = 0;
      end
      if (!do_m && prev_do) check("high_time", hi_len, cur_hi);
      if (do_m) begin
        hi_len++;
        check("do_implies_busy", busy_m, 1);
      end
      since_rise++;
      if (busy_m) busy_len++;
      if (!busy_m && prev_busy) begin
        check("done_at_end", done_m, 1);
        ok = (exp_q.size() > 0) && exp_q[0].is_frame;
        check("frame_expected", ok, 1);
        if (ok) begin
          e = exp_q.pop_front();
          check("busy_len", busy_len, e.val);
        end
        last_busy_len = busy_len;
        busy_len = 0;
      end
      if (done_m) begin
        check("done_only_after_busy", (prev_busy && !busy_m), 1);
        done_cnt++;
      end
      prev_do   = do_m;
      prev_busy = busy_m;
    end
  end

  // Returns during the done cycle, just after the monitor has processed it.
  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done_m) seen = 1;
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame_a(input logic [47:0] fr, input int br);
    frame_a    = fr;
    brightness = 8'(br);
    push_model({16'd0, fr}, 24, br);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    check("latency_do_a", do_a, 1);
    check("latency_busy_a", busy_a, 1);
  endtask

  task automatic start_frame_b(input logic [63:0] fr, input int br);
    frame_b    = fr;
    brightness = 8'(br);
    push_model(fr, 32, br);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    check("latency_do_b", do_b, 1);
    check("latency_busy_b", busy_b, 1);
  endtask

  initial begin
    logic [63:0] rnd;
    logic [47:0] fr_keep;
    int br_keep, d0;

    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    frame_a = '0;
    frame_b = '0;
    brightness = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_do", do_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_led", int'(led_a), 0);
    check("rst_do_b", do_b, 0);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One 1-bit at each end of LED0, LED1 all zero, full brightness.
    start_frame_a({24'h000000, 24'h800001}, 255);
    wait_done();
    check("busy_len_298", last_busy_len, 298);

    // Scaling at brightness 127.
    start_frame_a({24'h000000, 24'hFF8000}, 127);
    wait_done();

    // Mid-frame start and input changes must be ignored.
    start_frame_a({24'h000000, 24'h800001}, 255);
    d0 = done_cnt;
    repeat (100) @(posedge clk);
    #1;
    rnd = {$urandom, $urandom};
    frame_a = rnd[47:0];
    brightness = 8'($urandom_range(0, 255));
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_done();
    repeat (20) @(posedge clk);
    #1;
    check("one_done_on_restart", done_cnt - d0, 1);

    // Random frames, brightness 0 included.
    for (int i = 0; i < 5; i++) begin
      rnd = {$urandom, $urandom};
      start_frame_a(rnd[47:0], (i == 0) ? 0 : int'($urandom_range(0, 255)));
      wait_done();
    end

    // Start accepted in the done cycle; second frame identical to the first.
    rnd = {$urandom, $urandom};
    fr_keep = rnd[47:0];
    br_keep = int'($urandom_range(1, 255));
    start_frame_a(fr_keep, br_keep);
    wait_done();
    start_frame_a(fr_keep, br_keep);
    wait_done();

    // Reset during SEND_HIGH of LED1 bit 5 (stream bit 42).
    rnd = {$urandom, $urandom};
    start_frame_a(rnd[47:0], 255);
    repeat (42 * TB) @(posedge clk);
    #1;
    check("pre_reset_do", do_a, 1);
    check("pre_reset_led", int'(led_a), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_do", do_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_led", int'(led_a), 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check("idle_after_reset_busy", busy_a, 0);
    check("idle_after_reset_do", do_a, 0);
    check("no_done_after_reset", done_cnt - d0, 0);

    // 32-bit RGBW instance.
    sel = 1'b1;
    @(posedge clk);
    #1;
    start_frame_b({32'h0, 32'h00000001}, 255);
    wait_done();
    check("busy_len_394", last_busy_len, 394);
    rnd = {$urandom, $urandom};
    start_frame_b(rnd, int'($urandom_range(0, 255)));
    wait_done();

    repeat (10) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/strip_frame_driver.md
STRIP_FRAME_DRIVER -- requirements
Module: strip_frame_driver

Interface
REQ-001 SHALL provide parameter NUM_LEDS, default 8, giving the number of LEDs per frame (minimum 1).
REQ-002 SHALL provide parameter BITS_PER_LED, default 24, giving bits per LED: 24 for RGB, 32 for RGBW.
REQ-003 SHALL provide parameter T0H, default 20, giving the high time in clk cycles for a 0 bit.
REQ-004 SHALL provide parameter T1H, default 40, giving the high time in clk cycles for a 1 bit.
REQ-005 SHALL provide parameter TBIT, default 61, giving the total bit period in clk cycles (1220 ns at 50 MHz).
REQ-006 SHALL provide parameter TRESET, default 2500, giving the low latch gap in clk cycles after the last bit.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1 bit: request to transmit one frame.
REQ-010 SHALL have port frame, input, NUM_LEDS*BITS_PER_LED bits: pixel data, with LED i at [i*BITS_PER_LED +: BITS_PER_LED].
REQ-011 SHALL have port brightness, input, 8 bits: global scale applied to every 8-bit colour field.
REQ-012 SHALL have port DO, output, 1 bit: serial data line to the strip.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame or its latch gap is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the latch gap completes.
REQ-015 SHALL have port led_index, output, max(1,$clog2(NUM_LEDS)) bits: the index of the LED currently being sent.

Function
REQ-016 SHALL fail elaboration unless 0<T0H<T1H<TBIT, TRESET>=1 and BITS_PER_LED is 24 or 32.
REQ-017 SHALL implement states IDLE, SEND_HIGH, SEND_LOW and LATCH; DO is 1 only in SEND_HIGH.
REQ-018 SHALL accept start only in IDLE; start in any other state is ignored with no queuing.
REQ-019 SHALL, on accepting start, capture frame and brightness into shadow registers; later input changes do not affect the frame in flight.
REQ-020 SHALL enter SEND_HIGH with busy=1 and DO=1 on the cycle after start is sampled (1-cycle latency).
REQ-021 SHALL send LED 0 first, and within each LED send MSB first.
REQ-022 SHALL, for each bit, hold DO high for T1H cycles if the bit is 1 or T0H cycles if it is 0, then low for the remainder of exactly TBIT cycles; there are no gap cycles between bits or LEDs.
REQ-023 SHALL scale each 8-bit field c of the current LED as (c*(brightness+1))>>8 using a 16-bit product; brightness=255 passes data unchanged and brightness=0 yields 0.
REQ-024 SHALL make led_index equal the LED being sent during SEND states, and 0 in IDLE and LATCH.
REQ-025 SHALL, after the low phase of the last bit of LED NUM_LEDS-1, enter LATCH with DO=0 for exactly TRESET cycles.
REQ-026 SHALL, at the end of LATCH, enter IDLE, drive busy=0 and pulse done=1 for that first IDLE cycle only.
REQ-027 SHALL accept a start sampled in the done cycle, beginning a new frame on the next cycle.
REQ-028 SHALL keep busy high for exactly NUM_LEDS*BITS_PER_LED*TBIT+TRESET cycles per frame.
REQ-029 SHALL size all cycle counters to hold max(TBIT,TRESET) and the bit counter to hold BITS_PER_LED, with no wrap inside a frame.

Reset
REQ-030 SHALL, while rst_n=0, immediately force DO=0, busy=0, done=0, led_index=0, state=IDLE, all counters=0 and the shadow registers=0.
REQ-031 SHALL abort any frame in progress on reset with no done pulse; the next frame needs a fresh start after rst_n=1.

Verification (NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, TRESET=10 unless stated)
REQ-032 SHALL check: frame={24'h000000,24'h800001}, brightness=255, start pulse -> LED0 bit23 DO high 4/low 2, bits22..1 high 2/low 4, bit0 high 4/low 2; LED1 all 0-bits; busy high 298 cycles; done one cycle.
REQ-033 SHALL check: LED0=24'hFF8000, brightness=127 -> fields sent as 8'h7F, 8'h40, 8'h00.
REQ-034 SHALL check: start re-pulsed and frame changed mid-frame -> waveform is identical to REQ-032 and exactly one done pulse occurs.
REQ-035 SHALL check: rst_n=0 during the SEND_HIGH of LED1 bit 5 -> DO=0 and busy=0 before the next clk edge, no done pulse, and IDLE held after release.
REQ-036 SHALL check: BITS_PER_LED=32, frame={32'h0,32'h00000001}, brightness=255 -> 64 bits sent; busy high 394 cycles; only LED0 bit0 has high time 4.
REQ-037 SHALL check: start asserted during the done cycle -> DO rises on the next cycle and the second frame matches the first.
